// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types and constants
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 7;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of fetch entries with flush
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t wdata,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic do_push;
    logic do_pop;

    assign do_pop  = pop && count != '0;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign head    = mem[rd_ptr];

    // pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // storage needs no reset; only slots below count are ever observed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, in-order imem requests, response buffering and decode handshake
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 2;

    logic [31:0]   pc;
    logic [CW-1:0] live_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] tag_cnt;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_live;
    logic          buf_push;
    logic          buf_pop;
    fetch_entry_t  buf_wdata;
    fetch_entry_t  buf_head;
    fetch_entry_t  tag_wdata;
    fetch_entry_t  tag_head;
    logic          unused_bits;

    // a response retires a stale request first; only then does it belong to a live one
    assign rsp_drop = imem_rsp_valid && drop_cnt != '0;
    assign rsp_live = imem_rsp_valid && drop_cnt == '0 && live_cnt != '0;

    // buffered + live + stale never exceeds the buffer size, so a push never meets a full FIFO
    assign imem_req_valid = !rst && !redirect_valid &&
                            (SW'(fifo_cnt) + SW'(live_cnt) + SW'(drop_cnt) < SW'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign buf_push  = rsp_live && !redirect_valid;
    assign buf_pop   = id_valid && id_ready && !redirect_valid;
    assign buf_wdata = '{instr: imem_rsp_data, pc: tag_head.pc};
    assign tag_wdata = '{instr: '0, pc: pc};

    assign id_valid  = !rst && fifo_cnt != '0;
    assign id_instr  = id_valid ? buf_head.instr : '0;
    assign id_pc     = id_valid ? buf_head.pc : '0;
    assign id_opcode = id_instr[OPCODE_LSB +: OPCODE_W];

    assign unused_bits = ^{redirect_pc[1:0], tag_head.instr, tag_cnt};

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (buf_push),
        .wdata (buf_wdata),
        .pop   (buf_pop),
        .head  (buf_head),
        .count (fifo_cnt)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_tagq (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (req_fire),
        .wdata (tag_wdata),
        .pop   (buf_push),
        .head  (tag_head),
        .count (tag_cnt)
    );

    // pc advance and in-flight accounting; a redirect turns every live request into a drop
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            live_cnt <= '0;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            pc       <= {redirect_pc[31:2], 2'b00};
            live_cnt <= '0;
            drop_cnt <= drop_cnt + live_cnt - CW'(rsp_drop || rsp_live);
        end else begin
            pc       <= req_fire ? pc + 32'd4 : pc;
            live_cnt <= live_cnt + CW'(req_fire) - CW'(rsp_live);
            drop_cnt <= drop_cnt - CW'(rsp_drop);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scenario tasks plus an imem responder/scoreboard for fetch_unit
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;

    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    bit   rsp_en;
    req_t pend[$];
    ent_t exp_q[$];

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : {a[26:2], 7'h33};
    endfunction

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic smp_until_req();
        for (int i = 0; i < 20; i++) begin
            smp();
            if (imem_req_valid) break;
        end
    endtask

    task automatic smp_until_id();
        for (int i = 0; i < 20; i++) begin
            smp();
            if (id_valid) break;
        end
    endtask

    // imem responder (one-cycle minimum latency, in order) and decode-side scoreboard
    initial begin : imem_sb
        int          tot;
        bit          exp_req;
        ent_t        e;
        req_t        cur;
        logic [31:0] exp_pc;
        imem_rsp_valid = 0;
        imem_rsp_data  = 0;
        exp_pc         = RESET_PC;
        cur            = '{32'h0, 1'b0};
        forever begin
            @(negedge clk);
            if (rst) begin
                pend.delete();
                exp_q.delete();
                exp_pc = RESET_PC;
            end else begin
                tot     = pend.size() + (imem_rsp_valid ? 1 : 0) + exp_q.size();
                exp_req = !redirect_valid && tot < DEPTH;
                chk_cnt++;
                if (imem_req_valid !== exp_req)
                    $display("FAIL req_valid_model: got %b want %b (t=%0t)", imem_req_valid, exp_req, $time);
                else pass_cnt++;
                if (imem_req_valid) begin
                    chk_cnt++;
                    if (imem_req_addr !== exp_pc)
                        $display("FAIL req_addr_model: got %h want %h", imem_req_addr, exp_pc);
                    else pass_cnt++;
                end
                chk_cnt++;
                if (id_valid !== (exp_q.size() != 0))
                    $display("FAIL id_valid_model: got %b want %b (t=%0t)", id_valid, exp_q.size() != 0, $time);
                else pass_cnt++;
                if (!id_valid) begin
                    chk_cnt++;
                    if ({id_instr, id_pc, id_opcode} !== 71'h0)
                        $display("FAIL id_zero: got instr %h pc %h want 0", id_instr, id_pc);
                    else pass_cnt++;
                end
                if (id_valid && id_ready && !redirect_valid) begin
                    chk_cnt++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL id_unexpected: got pc %h want nothing", id_pc);
                    end else begin
                        e = exp_q.pop_front();
                        if (id_pc !== e.pc || id_instr !== e.instr || id_opcode !== e.instr[6:0])
                            $display("FAIL id_entry: got pc %h instr %h op %h want pc %h instr %h",
                                     id_pc, id_instr, id_opcode, e.pc, e.instr);
                        else pass_cnt++;
                    end
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    foreach (pend[i]) pend[i].stale = 1;
                    exp_pc = {redirect_pc[31:2], 2'b00};
                end else if (imem_rsp_valid && !cur.stale) begin
                    exp_q.push_back('{cur.addr, mem_word(cur.addr)});
                end
                if (imem_req_valid && imem_req_ready) begin
                    pend.push_back('{imem_req_addr, 1'b0});
                    exp_pc = exp_pc + 32'd4;
                end
            end
            @(posedge clk);
            #1;
            if (!rst && rsp_en && pend.size() != 0) begin
                cur = pend.pop_front();
                imem_rsp_valid = 1;
                imem_rsp_data  = mem_word(cur.addr);
            end else begin
                imem_rsp_valid = 0;
                imem_rsp_data  = 0;
            end
        end
    end

    task automatic test_reset();
        repeat (3) nxt();
        smp();
        chk_cnt++;
        if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", imem_req_valid);
        else pass_cnt++;
        chk_cnt++;
        if (id_valid !== 1'b0) $display("FAIL rst_id_valid: got %b want 0", id_valid);
        else pass_cnt++;
        chk_cnt++;
        if (id_pc !== 32'h0 || id_instr !== 32'h0) $display("FAIL rst_id_zero: got pc %h instr %h want 0", id_pc, id_instr);
        else pass_cnt++;
    endtask

    task automatic test_first_fetch();
        nxt();
        rst = 0;
        smp();
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
            $display("FAIL first_addr: got v%b %h want v1 00000000", imem_req_valid, imem_req_addr);
        else pass_cnt++;
        smp();
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4)
            $display("FAIL second_addr: got v%b %h want v1 00000004", imem_req_valid, imem_req_addr);
        else pass_cnt++;
        smp();
        chk_cnt++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h0050_0093 || id_opcode !== 7'h13)
            $display("FAIL first_instr: got v%b pc %h instr %h op %h want v1 0 00500093 13",
                     id_valid, id_pc, id_instr, id_opcode);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int nfire;
        nfire = 0;
        nxt();
        id_ready = 0;
        for (int i = 0; i < 10; i++) begin
            smp();
            if (imem_req_valid && imem_req_ready) nfire++;
        end
        chk_cnt++;
        if (nfire > DEPTH) $display("FAIL stall_fires: got %0d want <= %0d", nfire, DEPTH);
        else pass_cnt++;
        chk_cnt++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b1)
            $display("FAIL stall_full: got req_v %b id_v %b want 0 1", imem_req_valid, id_valid);
        else pass_cnt++;
        nxt();
        id_ready = 1;
        repeat (12) nxt();
    endtask

    task automatic test_redirect();
        nxt();
        rsp_en = 0;
        repeat (6) nxt();
        rsp_en         = 1;
        redirect_valid = 1;
        redirect_pc    = 32'h0000_0103;
        nxt();
        redirect_valid = 0;
        smp_until_req();
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100)
            $display("FAIL redir_addr: got v%b %h want v1 00000100", imem_req_valid, imem_req_addr);
        else pass_cnt++;
        smp_until_id();
        chk_cnt++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100)
            $display("FAIL redir_id_pc: got v%b %h want v1 00000100", id_valid, id_pc);
        else pass_cnt++;
        repeat (6) nxt();
    endtask

    task automatic test_redirect_collide();
        nxt();
        rsp_en = 0;
        repeat (6) nxt();
        rsp_en = 1;
        nxt();
        nxt();
        redirect_valid = 1;
        redirect_pc    = 32'h0000_0200;
        smp();
        chk_cnt++;
        if (imem_rsp_valid !== 1'b1 || id_valid !== 1'b1 || id_ready !== 1'b1)
            $display("FAIL collide_setup: got rsp %b id_v %b want 1 1", imem_rsp_valid, id_valid);
        else pass_cnt++;
        nxt();
        redirect_valid = 0;
        smp();
        chk_cnt++;
        if (id_valid !== 1'b0) $display("FAIL collide_empty: got id_valid %b want 0", id_valid);
        else pass_cnt++;
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200)
            $display("FAIL collide_addr: got v%b %h want v1 00000200", imem_req_valid, imem_req_addr);
        else pass_cnt++;
        repeat (6) nxt();
    endtask

    task automatic test_req_hold();
        logic [31:0] a0;
        nxt();
        imem_req_ready = 0;
        repeat (4) nxt();
        smp();
        a0 = imem_req_addr;
        chk_cnt++;
        if (imem_req_valid !== 1'b1) $display("FAIL hold_valid: got %b want 1", imem_req_valid);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk_cnt++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== a0)
                $display("FAIL hold_addr: got v%b %h want v1 %h", imem_req_valid, imem_req_addr, a0);
            else pass_cnt++;
        end
        nxt();
        imem_req_ready = 1;
        smp();
        smp();
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== a0 + 32'd4)
            $display("FAIL hold_release: got v%b %h want v1 %h", imem_req_valid, imem_req_addr, a0 + 32'd4);
        else pass_cnt++;
        nxt();
        redirect_valid = 1;
        redirect_pc    = 32'hFFFF_FFFC;
        nxt();
        redirect_valid = 0;
        smp_until_req();
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_top: got v%b %h want v1 fffffffc", imem_req_valid, imem_req_addr);
        else pass_cnt++;
        smp_until_req();
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
            $display("FAIL wrap_zero: got v%b %h want v1 00000000", imem_req_valid, imem_req_addr);
        else pass_cnt++;
        repeat (6) nxt();
    endtask

    task automatic test_reset_mid();
        nxt();
        id_ready = 0;
        repeat (8) nxt();
        smp();
        chk_cnt++;
        if (id_valid !== 1'b1 || imem_req_valid !== 1'b0)
            $display("FAIL mid_full: got id_v %b req_v %b want 1 0", id_valid, imem_req_valid);
        else pass_cnt++;
        nxt();
        rst = 1;
        nxt();
        smp();
        chk_cnt++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 || id_pc !== 32'h0)
            $display("FAIL mid_rst: got id_v %b req_v %b pc %h want 0 0 0", id_valid, imem_req_valid, id_pc);
        else pass_cnt++;
        nxt();
        rst      = 0;
        id_ready = 1;
        smp();
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC)
            $display("FAIL mid_restart: got v%b %h want v1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        else pass_cnt++;
        smp();
        smp();
        chk_cnt++;
        if (id_valid !== 1'b1 || id_pc !== RESET_PC)
            $display("FAIL mid_first_id: got v%b %h want v1 %h", id_valid, id_pc, RESET_PC);
        else pass_cnt++;
        repeat (10) nxt();
    endtask

    initial begin
        rst            = 1;
        imem_req_ready = 1;
        id_ready       = 1;
        redirect_valid = 0;
        redirect_pc    = 0;
        rsp_en         = 1;
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect();
        test_redirect_collide();
        test_req_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
